branch_pc_unit: RTL

//  Program-counter and conditional-branch sequencer directly downstream of the
//  CON flip-flop stage. Registers the branch condition from the C2 field and the
//  bus value, then commits PC <- PC + sext(offset) when the branch is taken.

---
 rtl/branch_pc_unit_if.sv | 29 ++
 rtl/branch_pc_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit_if.sv
// Control-side bundle for branch_pc_unit: strobes and operands from the control
// unit, and PC / branch status back to it.
interface branch_pc_unit_if #(
    parameter int PC_W  = 32,
    parameter int OFF_W = 19,
    parameter int CNT_W = 16
);
    logic             start;
    logic [1:0]       cond;
    logic [PC_W-1:0]  bus_in;
    logic [OFF_W-1:0] offset;
    logic             pc_inc;
    logic             pc_load;
    logic [PC_W-1:0]  pc;
    logic             con_q;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output start, cond, bus_in, offset, pc_inc, pc_load,
        input  pc, con_q, busy, done, taken_cnt
    );

    modport slave (
        input  start, cond, bus_in, offset, pc_inc, pc_load,
        output pc, con_q, busy, done, taken_cnt
    );
endinterface

// File: rtl/branch_pc_unit.sv
// Program counter with fetch increment, register-indirect load and a three-state
// conditional-branch sequencer (IDLE -> EVAL -> UPDATE) with a saturating taken count.
module branch_pc_unit #(
    parameter int              PC_W     = 32,
    parameter int              OFF_W    = 19,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             clear,
    branch_pc_unit_if.slave  pcu
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EVAL   = 2'b01,
        UPDATE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [PC_W-1:0]  pc_r;
    logic [PC_W-1:0]  pc_nxt_s;
    logic [1:0]       cond_q_r;
    logic [1:0]       cond_q_nxt_s;
    logic [PC_W-1:0]  bus_q_r;
    logic [PC_W-1:0]  bus_q_nxt_s;
    logic [OFF_W-1:0] offset_q_r;
    logic [OFF_W-1:0] offset_q_nxt_s;
    logic             con_q_r;
    logic             con_q_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic [CNT_W-1:0] taken_cnt_r;
    logic [CNT_W-1:0] taken_cnt_nxt_s;
    logic [PC_W-1:0]  offset_sext_s;

    // Branch condition decode of the C2 field against the latched bus value
    function automatic logic eval_cond(input logic [1:0] c, input logic [PC_W-1:0] b);
        logic r;
        case (c)
            2'b00:   r = (b == {PC_W{1'b0}});
            2'b01:   r = (b != {PC_W{1'b0}});
            2'b10:   r = ~b[PC_W-1];
            2'b11:   r = b[PC_W-1];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign offset_sext_s = {{(PC_W-OFF_W){offset_q_r[OFF_W-1]}}, offset_q_r};

    // FSM state register
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; strobes are only honoured in IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pcu.start) begin
                    state_nxt_s = EVAL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EVAL:    state_nxt_s = UPDATE;
            UPDATE:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output / datapath next values
    always_comb begin
        pc_nxt_s        = pc_r;
        cond_q_nxt_s    = cond_q_r;
        bus_q_nxt_s     = bus_q_r;
        offset_q_nxt_s  = offset_q_r;
        con_q_nxt_s     = con_q_r;
        taken_cnt_nxt_s = taken_cnt_r;
        done_nxt_s      = 1'b0;
        busy_nxt_s      = (state_nxt_s != IDLE);
        case (state_r)
            IDLE: begin
                if (pcu.start) begin
                    cond_q_nxt_s   = pcu.cond;
                    bus_q_nxt_s    = pcu.bus_in;
                    offset_q_nxt_s = pcu.offset;
                end else if (pcu.pc_load) begin
                    pc_nxt_s = pcu.bus_in;
                end else if (pcu.pc_inc) begin
                    pc_nxt_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            EVAL: begin
                con_q_nxt_s = eval_cond(cond_q_r, bus_q_r);
            end
            UPDATE: begin
                done_nxt_s = 1'b1;
                if (con_q_r) begin
                    pc_nxt_s = pc_r + offset_sext_s;
                    if (&taken_cnt_r) begin
                        taken_cnt_nxt_s = taken_cnt_r;
                    end else begin
                        taken_cnt_nxt_s = taken_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            default: begin
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; clear discards any in-flight branch
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            pc_r        <= RESET_PC;
            cond_q_r    <= 2'b00;
            bus_q_r     <= {PC_W{1'b0}};
            offset_q_r  <= {OFF_W{1'b0}};
            con_q_r     <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            taken_cnt_r <= {CNT_W{1'b0}};
        end else begin
            pc_r        <= pc_nxt_s;
            cond_q_r    <= cond_q_nxt_s;
            bus_q_r     <= bus_q_nxt_s;
            offset_q_r  <= offset_q_nxt_s;
            con_q_r     <= con_q_nxt_s;
            done_r      <= done_nxt_s;
            busy_r      <= busy_nxt_s;
            taken_cnt_r <= taken_cnt_nxt_s;
        end
    end

    assign pcu.pc        = pc_r;
    assign pcu.con_q     = con_q_r;
    assign pcu.busy      = busy_r;
    assign pcu.done      = done_r;
    assign pcu.taken_cnt = taken_cnt_r;

endmodule
